// File: rtl/multicycle_data_path_if.sv
// Control/debug bundle between a multicycle control FSM (master) and the datapath (slave).
// Latency: pure wiring; every strobe is sampled by the datapath on the same rising clk edge.
// Backpressure: none; the datapath consumes one control word every cycle.
// Signals: PCEn, IorD, Memwrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA,
//          ALUsrcB[1:0], ALUControl[2:0], PCsrc, addressTest[4:0] (master -> slave),
//          outputTest[31:0] (slave -> master, combinational debug read).
interface multicycle_data_path_if;
  logic        PCEn;
  logic        IorD;
  logic        Memwrite;
  logic        IRWrite;
  logic        RegDst;
  logic        MemtoReg;
  logic        RegWrite;
  logic        ALUsrcA;
  logic [1:0]  ALUsrcB;
  logic [2:0]  ALUControl;
  logic        PCsrc;
  logic [4:0]  addressTest;
  logic [31:0] outputTest;

  modport master (
    output PCEn, IorD, Memwrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUsrcA, ALUsrcB, ALUControl, PCsrc, addressTest,
    input  outputTest
  );

  modport slave (
    input  PCEn, IorD, Memwrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUsrcA, ALUsrcB, ALUControl, PCsrc, addressTest,
    output outputTest
  );
endinterface

// File: rtl/multicycle_data_path.sv
// 32-bit multicycle MIPS-style datapath (PC, unified memory, IR, MDR, regfile, A/B, ALU, ALUOut).
// Latency: one control state per clk; memory/regfile reads and the debug port are combinational.
// Backpressure: none; all strobes come from an external controller every cycle.
// Ports: clk, rst (async active-high), bus (multicycle_data_path_if.slave: control strobes,
//        addressTest in, outputTest out).
module multicycle_data_path #(
  parameter int MEM_WORDS = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  multicycle_data_path_if.slave        bus
);

  localparam int AW = $clog2(MEM_WORDS);

  // Architectural storage: not touched by reset.
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] rf  [32];

  // Sequential datapath registers.
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] alu_out;

  // Combinational nets.
  logic [31:0] mem_addr;
  logic [AW-1:0] word_idx;
  logic [31:0] mem_data;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] imm_sext;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic [31:0] pc_next;

  // ---------------- memory ----------------
  assign mem_addr = bus.IorD ? alu_out : pc;
  // Word-aligned byte address; bits above the array depth wrap.
  assign word_idx = mem_addr[AW+1:2];
  assign mem_data = mem[word_idx];

  always_ff @(posedge clk) begin
    if (bus.Memwrite) begin
      mem[word_idx] <= b_reg;
    end
  end

  // ---------------- register file ----------------
  assign rs_idx  = ir[25:21];
  assign rt_idx  = ir[20:16];
  assign rd_idx  = ir[15:11];
  assign wr_idx  = bus.RegDst ? rd_idx : rt_idx;
  assign wr_data = bus.MemtoReg ? mdr : alu_out;

  // $0 is forced to read zero regardless of what the array holds.
  assign rd1 = (rs_idx == 5'd0) ? 32'd0 : rf[rs_idx];
  assign rd2 = (rt_idx == 5'd0) ? 32'd0 : rf[rt_idx];
  assign bus.outputTest = (bus.addressTest == 5'd0) ? 32'd0 : rf[bus.addressTest];

  always_ff @(posedge clk) begin
    if (bus.RegWrite && (wr_idx != 5'd0)) begin
      rf[wr_idx] <= wr_data;
    end
  end

  // ---------------- ALU ----------------
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign src_a    = bus.ALUsrcA ? a_reg : pc;

  always_comb begin
    src_b = b_reg;
    case (bus.ALUsrcB)
      2'd0:    src_b = b_reg;
      2'd1:    src_b = 32'd4;
      2'd2:    src_b = imm_sext;
      default: src_b = {imm_sext[29:0], 2'b00};
    endcase
  end

  always_comb begin
    alu_result = 32'd0;
    case (bus.ALUControl)
      3'b000:  alu_result = src_a & src_b;
      3'b001:  alu_result = src_a | src_b;
      3'b010:  alu_result = src_a + src_b;
      3'b110:  alu_result = src_a - src_b;
      3'b111:  alu_result = {31'd0, ($signed(src_a) < $signed(src_b))};
      default: alu_result = 32'd0;
    endcase
  end

  // PCsrc=0 takes the ALU result of this very cycle (e.g. PC+4 during fetch).
  assign pc_next = bus.PCsrc ? alu_out : alu_result;

  // ---------------- sequential datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= 32'd0;
      ir      <= 32'd0;
      mdr     <= 32'd0;
      a_reg   <= 32'd0;
      b_reg   <= 32'd0;
      alu_out <= 32'd0;
    end else begin
      if (bus.PCEn) begin
        pc <= pc_next;
      end
      if (bus.IRWrite) begin
        ir <= mem_data;
      end
      // Non-architectural latches reload every cycle.
      mdr     <= mem_data;
      a_reg   <= rd1;
      b_reg   <= rd2;
      alu_out <= alu_result;
    end
  end

  // Opcode and out-of-range address bits are decoded by the external controller only.
  logic unused_bits;
  assign unused_bits = ^{mem_addr[31:AW+2], mem_addr[1:0], ir[31:26]};

endmodule

// File: tb/tb_multicycle_data_path.sv
module tb_multicycle_data_path;

  localparam int S_PC  = 0;
  localparam int S_IR  = 1;
  localparam int S_ALU = 2;
  localparam int S_MDR = 3;
  localparam int S_A   = 4;
  localparam int S_B   = 5;
  localparam int S_DBG = 6;
  localparam int S_MEM = 7;
  localparam int S_RF  = 8;

  typedef struct {
    string       name;
    int          sel;
    int          idx;
    logic [31:0] exp;
  } sb_ent_t;

  logic clk;
  logic rst;
  multicycle_data_path_if bus();

  multicycle_data_path #(.MEM_WORDS(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sb_ent_t sb_q[$];
  event    obs_ev;
  int      errors = 0;
  int      checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- monitor: pops expectations when an observation is presented ----------------
  initial begin
    sb_ent_t     ent;
    logic [31:0] act;
    forever begin
      @(obs_ev);
      #1;
      while (sb_q.size() > 0) begin
        ent = sb_q.pop_front();
        act = 32'hxxxxxxxx;
        case (ent.sel)
          S_PC:    act = dut.pc;
          S_IR:    act = dut.ir;
          S_ALU:   act = dut.alu_out;
          S_MDR:   act = dut.mdr;
          S_A:     act = dut.a_reg;
          S_B:     act = dut.b_reg;
          S_DBG:   act = bus.outputTest;
          S_MEM:   act = dut.mem[ent.idx[5:0]];
          default: act = dut.rf[ent.idx[4:0]];
        endcase
        checks++;
        if (act !== ent.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", ent.name, act, ent.exp);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic expect_val(input string name, input int sel, input int idx, input logic [31:0] exp);
    sb_ent_t e;
    if (sel == S_DBG) bus.addressTest = idx[4:0];
    e.name = name;
    e.sel  = sel;
    e.idx  = idx;
    e.exp  = exp;
    sb_q.push_back(e);
    -> obs_ev;
    #2;
  endtask

  task automatic ctrl(input logic pcen, input logic iord, input logic memwr, input logic irwr,
                      input logic regdst, input logic memtoreg, input logic regwr,
                      input logic srca, input logic [1:0] srcb, input logic [2:0] aluc,
                      input logic pcsrc);
    bus.PCEn       = pcen;
    bus.IorD       = iord;
    bus.Memwrite   = memwr;
    bus.IRWrite    = irwr;
    bus.RegDst     = regdst;
    bus.MemtoReg   = memtoreg;
    bus.RegWrite   = regwr;
    bus.ALUsrcA    = srca;
    bus.ALUsrcB    = srcb;
    bus.ALUControl = aluc;
    bus.PCsrc      = pcsrc;
  endtask

  task automatic idle();
    ctrl(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'b000, 0);
  endtask

  task automatic fetch();
    ctrl(1, 0, 0, 1, 0, 0, 0, 0, 2'd1, 3'b010, 0);
  endtask

  task automatic alu_op(input logic srca, input logic [1:0] srcb, input logic [2:0] aluc);
    ctrl(0, 0, 0, 0, 0, 0, 0, srca, srcb, aluc, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed program ----------------
  initial begin
    rst = 1'b1;
    bus.addressTest = 5'd0;
    idle();
    for (int i = 0; i < 64; i++) dut.mem[i[5:0]] = 32'd0;
    for (int i = 0; i < 32; i++) dut.rf[i[4:0]] = 32'd0;
    dut.mem[0]  = 32'h8C0A0020;   // lw  $10, 32($0)
    dut.mem[1]  = 32'h01545020;   // add $10, $10, $20
    dut.mem[2]  = 32'hAC650025;   // sw  $5, 37($3)
    dut.mem[3]  = 32'h20001234;   // addi $0, $0, 0x1234
    dut.mem[8]  = 32'd5;          // byte address 32
    dut.mem[13] = 32'hCAFEF00D;   // aliased by byte address 0x1234
    dut.rf[20]  = 32'd10;
    dut.rf[3]   = 32'd3;
    dut.rf[5]   = 32'd5;

    step();
    expect_val("reset_pc", S_PC, 0, 32'd0);
    expect_val("reset_ir", S_IR, 0, 32'd0);
    expect_val("reset_aluout", S_ALU, 0, 32'd0);
    expect_val("reset_dbg0", S_DBG, 0, 32'd0);
    step();
    rst = 1'b0;

    // lw $10,32($0)
    fetch();                        step();
    expect_val("fetch1_ir", S_IR, 0, 32'h8C0A0020);
    expect_val("fetch1_pc", S_PC, 0, 32'd4);
    idle();                         step();
    alu_op(1, 2'd2, 3'b010);        step();
    expect_val("lw_addr", S_ALU, 0, 32'd32);
    ctrl(0, 1, 0, 0, 0, 0, 0, 1, 2'd2, 3'b010, 0); step();
    expect_val("lw_mdr", S_MDR, 0, 32'd5);
    ctrl(0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 3'b000, 0); step();
    expect_val("lw_r10", S_DBG, 10, 32'd5);

    // add $10,$10,$20
    fetch();                        step();
    expect_val("fetch2_ir", S_IR, 0, 32'h01545020);
    expect_val("fetch2_pc", S_PC, 0, 32'd8);
    idle();                         step();
    expect_val("add_a", S_A, 0, 32'd5);
    expect_val("add_b", S_B, 0, 32'd10);
    alu_op(1, 2'd0, 3'b010);        step();
    expect_val("add_exec", S_ALU, 0, 32'd15);
    ctrl(0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 3'b000, 0); step();
    expect_val("add_r10", S_DBG, 10, 32'd15);
    expect_val("add_r20", S_DBG, 20, 32'd10);

    // ALU ops on A=3, B=5, then sw $5,37($3)
    fetch();                        step();
    expect_val("fetch3_ir", S_IR, 0, 32'hAC650025);
    idle();                         step();
    expect_val("sw_a", S_A, 0, 32'd3);
    expect_val("sw_b", S_B, 0, 32'd5);
    alu_op(1, 2'd0, 3'b110);        step();
    expect_val("alu_sub", S_ALU, 0, 32'hFFFFFFFE);
    alu_op(1, 2'd0, 3'b111);        step();
    expect_val("alu_slt_true", S_ALU, 0, 32'd1);
    alu_op(0, 2'd0, 3'b111);        step();   // PC(12) < 5 is false
    expect_val("alu_slt_false", S_ALU, 0, 32'd0);
    alu_op(1, 2'd0, 3'b000);        step();
    expect_val("alu_and", S_ALU, 0, 32'd1);
    alu_op(1, 2'd0, 3'b001);        step();
    expect_val("alu_or", S_ALU, 0, 32'd7);
    alu_op(1, 2'd0, 3'b011);        step();
    expect_val("alu_undef", S_ALU, 0, 32'd0);
    alu_op(1, 2'd2, 3'b010);        step();
    expect_val("sw_addr", S_ALU, 0, 32'd40);
    ctrl(0, 1, 1, 0, 0, 0, 0, 1, 2'd2, 3'b010, 0); step();
    expect_val("sw_mem10", S_MEM, 10, 32'd5);
    expect_val("sw_mem8_kept", S_MEM, 8, 32'd5);

    // addi to $0, then jump via ALUOut on the same edge
    fetch();                        step();
    expect_val("fetch4_ir", S_IR, 0, 32'h20001234);
    expect_val("fetch4_pc", S_PC, 0, 32'd16);
    idle();                         step();
    alu_op(1, 2'd3, 3'b010);        step();
    expect_val("imm_shift", S_ALU, 0, 32'h000048D0);
    alu_op(1, 2'd2, 3'b010);        step();
    expect_val("imm_add", S_ALU, 0, 32'h00001234);
    ctrl(1, 0, 0, 0, 0, 0, 1, 0, 2'd0, 3'b000, 1); step();
    expect_val("zero_dbg", S_DBG, 0, 32'd0);
    expect_val("zero_rf", S_RF, 0, 32'd0);
    expect_val("jump_pc", S_PC, 0, 32'h00001234);

    // address wrap: byte 0x1234 aliases word 13
    fetch();                        step();
    expect_val("wrap_ir", S_IR, 0, 32'hCAFEF00D);
    expect_val("wrap_pc", S_PC, 0, 32'h00001238);

    // asynchronous reset mid-cycle
    idle();
    rst = 1'b1;
    expect_val("arst_pc", S_PC, 0, 32'd0);
    expect_val("arst_ir", S_IR, 0, 32'd0);
    expect_val("arst_aluout", S_ALU, 0, 32'd0);
    expect_val("arst_mdr", S_MDR, 0, 32'd0);
    step();
    expect_val("arst_r10_kept", S_DBG, 10, 32'd15);
    expect_val("arst_mem10_kept", S_MEM, 10, 32'd5);
    rst = 1'b0;
    fetch();                        step();
    expect_val("refetch_ir", S_IR, 0, 32'h8C0A0020);
    expect_val("refetch_pc", S_PC, 0, 32'd4);
    idle();

    for (int k = 0; k < 20 && sb_q.size() > 0; k++) #1;
    if (sb_q.size() > 0) begin
      $display("FAIL drain: %0d expectations never compared, required 0", sb_q.size());
      errors += sb_q.size();
      checks += sb_q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
